sha_stream: RTL and testbench

Byte-stream front end for the `sha` top, playing the initiator role on its `Data`/`Enable`/`Hash`/`Ready` interface. It accepts exactly `Nl` message bytes over a valid/ready input stream and assembles them into the `Data` array. It then pulses `Enable`, waits for the hash, and returns the `Nk/8` hash bytes over a valid/ready output stream, most significant byte first. It sits between a host bus/FIFO and one `sha` instance.

---
 rtl/sha_const.sv | 33 +++
 rtl/sha_stream.sv | 96 +++++++++
 tb/tb_sha_stream.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_const.sv
// Shared constants, state encoding and register layout for the sha core and
// its byte-stream front end.
package sha_const;

    localparam int Nl     = 64;   // message bytes per operation
    localparam int Nk     = 256;  // hash width in bits
    localparam int NbHash = Nk / 8;
    localparam int NpMax  = 8;    // largest Ready-pulse count a front end may be built for

    localparam int BcntW = $clog2((Nl > NbHash) ? Nl : NbHash);
    localparam int RcntW = $clog2(NpMax) + 1;
    localparam int DidxW = $clog2(Nl);
    localparam int HidxW = $clog2(NbHash);

    typedef enum logic [1:0] {
        LOAD  = 2'h0,
        START = 2'h1,
        WAIT  = 2'h2,
        SEND  = 2'h3
    } state_type;

    // Byte 0 of both arrays is the most significant byte of the packed vector.
    typedef struct packed {
        state_type              state;
        logic [BcntW-1:0]       bcnt;
        logic [RcntW-1:0]       rcnt;
        logic [0:Nl-1][7:0]     data;
        logic [0:NbHash-1][7:0] hreg;
    } reg_type;

    localparam reg_type RegReset = '{state: LOAD, bcnt: '0, rcnt: '0, data: '0, hreg: '0};

endpackage

// File: rtl/sha_stream.sv
// Byte-stream front end for one sha core: collects Nl message bytes, starts the
// core, and returns the hash most significant byte first.
module sha_stream
    import sha_const::*;
#(
    parameter int Np = 1
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic [7:0]           In_Data,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    output logic [7:0]           Out_Data,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic                 Out_Last,
    output logic [0:Nl-1][7:0]   Sha_Data,
    output logic                 Sha_Enable,
    input  logic [Nk-1:0]        Sha_Hash,
    input  logic                 Sha_Ready,
    output logic                 Busy
);

    reg_type r, rin;

    always_comb begin
        // NOTE: every output and rin gets a default first so no path leaves a latch.
        rin        = r;
        In_Ready   = 1'b0;
        Out_Valid  = 1'b0;
        Out_Data   = 8'h00;
        Out_Last   = 1'b0;
        Sha_Enable = 1'b0;

        unique case (r.state)
            LOAD: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    rin.data[r.bcnt[DidxW-1:0]] = In_Data;
                    if (r.bcnt == BcntW'(Nl - 1)) begin
                        rin.bcnt  = '0;
                        rin.state = START;
                    end else begin
                        rin.bcnt = r.bcnt + 1'b1;
                    end
                end
            end

            START: begin
                Sha_Enable = 1'b1;
                rin.rcnt   = '0;
                rin.state  = WAIT;
            end

            WAIT: begin
                if (Sha_Ready) begin
                    rin.rcnt = r.rcnt + 1'b1;
                    if (r.rcnt == RcntW'(Np - 1)) begin
                        rin.hreg  = Sha_Hash;
                        rin.state = SEND;
                    end
                end
            end

            SEND: begin
                Out_Valid = 1'b1;
                Out_Data  = r.hreg[r.bcnt[HidxW-1:0]];
                Out_Last  = (r.bcnt == BcntW'(NbHash - 1));
                if (Out_Ready) begin
                    if (Out_Last) begin
                        rin.bcnt  = '0;
                        rin.state = LOAD;
                    end else begin
                        rin.bcnt = r.bcnt + 1'b1;
                    end
                end
            end

            default: rin = RegReset;
        endcase
    end

    // NOTE: the message and hash arrays are reset too; Sha_Data must read all-zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= RegReset;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            r <= rin;
        end
    end

    assign Sha_Data = r.data;
    assign Busy     = (r.state != LOAD);

endmodule

// File: tb/tb_sha_stream.sv
// Bench for sha_stream: Np=1 and Np=2 instances driven from a shared stream,
// each paired with a timed sha stub, checked against a transaction-level model.
module tb_sha_stream;
    import sha_const::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, rst_b, sel;
    logic [7:0] in_data;
    logic       in_valid, out_ready, extra_ready;

    logic in_ready_a, out_valid_a, out_last_a, sha_enable_a, busy_a, stub_ready_a, sha_ready_a;
    logic in_ready_b, out_valid_b, out_last_b, sha_enable_b, busy_b, stub_ready_b, sha_ready_b;
    logic [7:0] out_data_a, out_data_b;
    logic [0:Nl-1][7:0] sha_data_a, sha_data_b;
    logic [Nk-1:0] sha_hash_a, sha_hash_b;
    int ready_cyc_a = 0, ready_cyc_b = 0;

    assign sha_ready_a = stub_ready_a | extra_ready;
    assign sha_ready_b = stub_ready_b | extra_ready;

    sha_stream #(.Np(1)) u_dut_a (
        .rst(rst_a), .clk(clk), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready_a),
        .Out_Data(out_data_a), .Out_Valid(out_valid_a), .Out_Ready(out_ready), .Out_Last(out_last_a),
        .Sha_Data(sha_data_a), .Sha_Enable(sha_enable_a), .Sha_Hash(sha_hash_a),
        .Sha_Ready(sha_ready_a), .Busy(busy_a)
    );

    sha_stream #(.Np(2)) u_dut_b (
        .rst(rst_b), .clk(clk), .In_Data(in_data), .In_Valid(in_valid), .In_Ready(in_ready_b),
        .Out_Data(out_data_b), .Out_Valid(out_valid_b), .Out_Ready(out_ready), .Out_Last(out_last_b),
        .Sha_Data(sha_data_b), .Sha_Enable(sha_enable_b), .Sha_Hash(sha_hash_b),
        .Sha_Ready(sha_ready_b), .Busy(busy_b)
    );

    // Observed side: whichever instance is currently under test.
    logic in_ready_o, out_valid_o, out_last_o, sha_enable_o, busy_o;
    logic [7:0] out_data_o;
    logic [0:Nl-1][7:0] sha_data_o;
    assign in_ready_o   = sel ? in_ready_b   : in_ready_a;
    assign out_valid_o  = sel ? out_valid_b  : out_valid_a;
    assign out_last_o   = sel ? out_last_b   : out_last_a;
    assign sha_enable_o = sel ? sha_enable_b : sha_enable_a;
    assign busy_o       = sel ? busy_b       : busy_a;
    assign out_data_o   = sel ? out_data_b   : out_data_a;
    assign sha_data_o   = sel ? sha_data_b   : sha_data_a;

    int n_tests = 0;
    int n_fail  = 0;
    logic [0:Nl-1][7:0] cur_msg;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Hash the stub reports: bytes 0x00..0x1F, most significant first.
    function automatic logic [Nk-1:0] ref_hash();
        logic [Nk-1:0] h;
        for (int i = 0; i < NbHash; i++) h[Nk-1-8*i -: 8] = 8'(i);
        return h;
    endfunction

    function automatic logic [Nk-1:0] junk_hash();
        logic [Nk-1:0] h;
        for (int i = 0; i < Nk / 32; i++) h[32*i +: 32] = $urandom;
        return h;
    endfunction

    // Stub for the Np=1 instance: one Ready pulse 10 cycles after Enable.
    initial begin
        int cd = 0;
        stub_ready_a = 1'b0;
        sha_hash_a   = '0;
        forever begin
            @(posedge clk); #1;
            stub_ready_a = 1'b0;
            sha_hash_a   = junk_hash();
            if (sha_enable_a) cd = 10;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    stub_ready_a = 1'b1;
                    sha_hash_a   = ref_hash();
                    ready_cyc_a  = cyc;
                end
            end
        end
    end

    // Stub for the Np=2 instance: all-0xFF on the first pulse, real hash on the second.
    initial begin
        int cd = 0;
        stub_ready_b = 1'b0;
        sha_hash_b   = '0;
        forever begin
            @(posedge clk); #1;
            stub_ready_b = 1'b0;
            sha_hash_b   = junk_hash();
            if (sha_enable_b) cd = 13;
            else if (cd > 0) begin
                cd--;
                if (cd == 3) begin
                    stub_ready_b = 1'b1;
                    sha_hash_b   = '1;
                end else if (cd == 0) begin
                    stub_ready_b = 1'b1;
                    sha_hash_b   = ref_hash();
                    ready_cyc_b  = cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_reset();
        check("rst_in_ready", in_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_last", out_last_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_enable", sha_enable_o, 0);
        check("rst_sha_data", sha_data_o, 0);
    endtask

    // Feeds one message; returns early after stop_after accepted bytes (reset tests).
    task automatic send_msg(input logic [0:Nl-1][7:0] msg, input int gap_pct,
                            input bit start_poke, input int stop_after);
        int k = 0;
        int budget = 4000;
        cur_msg = msg;
        while (k < Nl) begin
            if (budget == 0) begin
                check("in_timeout", k, Nl);
                return;
            end
            budget--;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = msg[k];
            @(negedge clk);
            check("in_ready_load", in_ready_o, 1);
            check("enable_in_load", sha_enable_o, 0);
            check("busy_in_load", busy_o, 0);
            if (in_valid) k++;
            step();
            if (k == stop_after) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid    = 1'b1;
        in_data     = 8'($urandom);
        extra_ready = start_poke;
        @(negedge clk);
        check("enable_pulse", sha_enable_o, 1);
        check("in_ready_start", in_ready_o, 0);
        check("busy_start", busy_o, 1);
        step();
        extra_ready = 1'b0;
        @(negedge clk);
        check("enable_single", sha_enable_o, 0);
        check("in_ready_wait", in_ready_o, 0);
        check("sha_data", sha_data_o, msg);
    endtask

    // Collects the hash bytes; called from the negedge of the first WAIT cycle.
    task automatic recv_hash(input int stall_byte, input bit rnd_ready, input bit poke,
                             input int stop_after);
        int i = 0;
        int stall = 0;
        int budget = 200;
        bit hs;
        while (!out_valid_o) begin
            if (budget == 0) begin
                check("hash_timeout", 0, 1);
                return;
            end
            budget--;
            check("in_ready_busy", in_ready_o, 0);
            step();
            in_data = 8'($urandom);
            @(negedge clk);
        end
        check("hash_latency", cyc, (sel ? ready_cyc_b : ready_cyc_a) + 1);
        budget = 2000;
        while (i < NbHash && budget > 0) begin
            budget--;
            check("out_valid", out_valid_o, 1);
            check("out_data", out_data_o, 8'(i));
            check("out_last", out_last_o, (i == NbHash - 1));
            check("in_ready_send", in_ready_o, 0);
            if (i == stall_byte && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
            end
            extra_ready = poke ? 1'($urandom_range(1)) : 1'b0;
            hs = out_ready;
            step();
            if (hs) i++;
            if (i == stop_after || i == NbHash) begin
                in_valid    = 1'b0;
                out_ready   = 1'b0;
                extra_ready = 1'b0;
            end
            if (i == stop_after) return;
            @(negedge clk);
        end
        if (i < NbHash) begin
            check("out_timeout", i, NbHash);
            return;
        end
        check("in_ready_turnaround", in_ready_o, 1);
        check("busy_turnaround", busy_o, 0);
        check("out_valid_idle", out_valid_o, 0);
        check("sha_data_hold", sha_data_o, cur_msg);
        step();
    endtask

    function automatic logic [0:Nl-1][7:0] seq_msg();
        logic [0:Nl-1][7:0] m;
        for (int i = 0; i < Nl; i++) m[i] = 8'(i);
        return m;
    endfunction

    function automatic logic [0:Nl-1][7:0] rand_msg();
        logic [0:Nl-1][7:0] m;
        for (int i = 0; i < Nl; i++) m[i] = 8'($urandom);
        return m;
    endfunction

    task automatic pulse_reset_a();
        rst_a = 1'b0;
        #1;
        check_reset();
        #1;
        rst_a = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; extra_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        step();
        rst_a = 1'b1;
        step();

        // Basic message, then input gaps with the same and with random bytes.
        send_msg(seq_msg(), 0, 1'b0, -1);
        recv_hash(-1, 1'b0, 1'b0, -1);
        send_msg(seq_msg(), 50, 1'b0, -1);
        recv_hash(-1, 1'b0, 1'b0, -1);
        send_msg(rand_msg(), 50, 1'b0, -1);
        recv_hash(-1, 1'b1, 1'b0, -1);

        // Backpressure on byte 0x07.
        send_msg(seq_msg(), 0, 1'b0, -1);
        recv_hash(7, 1'b0, 1'b0, -1);

        // Sha_Ready poked in START and SEND, then a fresh message must start at index 0.
        send_msg(rand_msg(), 30, 1'b1, -1);
        recv_hash(-1, 1'b1, 1'b1, -1);
        send_msg(rand_msg(), 0, 1'b0, -1);
        recv_hash(-1, 1'b0, 1'b0, -1);

        // Reset after 30 input bytes, then after 3 hash bytes.
        send_msg(rand_msg(), 20, 1'b0, 30);
        pulse_reset_a();
        send_msg(rand_msg(), 0, 1'b0, -1);
        recv_hash(-1, 1'b0, 1'b0, 3);
        pulse_reset_a();
        send_msg(seq_msg(), 0, 1'b0, -1);
        recv_hash(-1, 1'b1, 1'b0, -1);

        // Two Ready pulses per message.
        rst_a = 1'b0;
        sel   = 1'b1;
        @(negedge clk);
        check_reset();
        step();
        rst_b = 1'b1;
        step();
        send_msg(rand_msg(), 25, 1'b0, -1);
        recv_hash(-1, 1'b0, 1'b0, -1);
        send_msg(seq_msg(), 0, 1'b0, -1);
        recv_hash(3, 1'b1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
